// File: rtl/stopwatch_if.sv
// Button/level inputs and display-side outputs of the stopwatch core.
// The master drives the debounced controls; the slave is the timekeeping core.
interface stopwatch_if #(
  parameter int MIN_W = 6
);
  logic             pause_btn;
  logic             lap_btn;
  logic             adj;
  logic             sel;
  logic             dir;
  logic [MIN_W-1:0] minutes;
  logic [5:0]       seconds;
  logic [MIN_W-1:0] lap_minutes;
  logic [5:0]       lap_seconds;
  logic             lap_valid;
  logic             running;
  logic             expired;
  logic             rollover;
  logic             blank_min;
  logic             blank_sec;
  logic [1:0]       state_dbg;

  modport master (
    output pause_btn, lap_btn, adj, sel, dir,
    input  minutes, seconds, lap_minutes, lap_seconds, lap_valid,
    input  running, expired, rollover, blank_min, blank_sec, state_dbg
  );

  modport slave (
    input  pause_btn, lap_btn, adj, sel, dir,
    output minutes, seconds, lap_minutes, lap_seconds, lap_valid,
    output running, expired, rollover, blank_min, blank_sec, state_dbg
  );
endinterface

// File: rtl/stopwatch_core.sv
// Single-clock stopwatch: clock-enable prescalers, button edge detection,
// up/down counting with expiry, lap capture and adjust-mode digit blinking.
module stopwatch_core #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int ADJ_TICKS     = 50000000,
  parameter int BLINK_TICKS   = 10000000,
  parameter int MIN_MAX       = 59,
  parameter int MIN_W         = 6
) (
  input logic        clk,
  input logic        rst,
  stopwatch_if.slave bus
);
  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ADJ_TICKS > 1) ? $clog2(ADJ_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0]    SEC_LAST   = SW'(TICKS_PER_SEC - 1);
  localparam logic [AW-1:0]    ADJ_LAST   = AW'(ADJ_TICKS - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [MIN_W-1:0] MIN_LAST   = MIN_W'(MIN_MAX);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    ADJUST  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             resume, resume_n;
  logic [SW-1:0]    sec_cnt;
  logic [AW-1:0]    adj_cnt;
  logic [BW-1:0]    blink_cnt;
  logic             phase, phase_n;
  logic             armed, pause_q, lap_q;
  logic [MIN_W-1:0] min_q, min_n, lap_min_q;
  logic [5:0]       sec_q, sec_n, lap_sec_q;
  logic             lap_valid_q, rollover_q, rollover_n;
  logic             blank_min_q, blank_sec_q;
  logic             pause_edge, lap_edge, sec_tick, adj_tick, blink_tick;

  // armed suppresses a false edge from a button held high across reset release
  assign pause_edge = armed & bus.pause_btn & ~pause_q;
  assign lap_edge   = armed & bus.lap_btn & ~lap_q;
  assign sec_tick   = (state == RUN) && (sec_cnt == SEC_LAST);
  assign adj_tick   = (state == ADJUST) && (adj_cnt == ADJ_LAST);
  assign blink_tick = (state == ADJUST) && (blink_cnt == BLINK_LAST);

  always_comb begin
    state_n    = state;
    resume_n   = resume;
    min_n      = min_q;
    sec_n      = sec_q;
    rollover_n = 1'b0;
    case (state)
      RUN: begin
        if (sec_tick) begin
          if (!bus.dir) begin
            if (sec_q == 6'd59) begin
              sec_n = 6'd0;
              if (min_q == MIN_LAST) begin
                min_n      = '0;
                rollover_n = 1'b1;
              end else begin
                min_n = min_q + MIN_W'(1);
              end
            end else begin
              sec_n = sec_q + 6'd1;
            end
          end else if (min_q == '0 && sec_q == 6'd0) begin
            state_n = EXPIRED;
          end else if (sec_q == 6'd0) begin
            sec_n = 6'd59;
            min_n = min_q - MIN_W'(1);
          end else begin
            sec_n = sec_q - 6'd1;
          end
        end
        if (pause_edge && state_n == RUN) state_n = PAUSED;
      end
      PAUSED: begin
        if (pause_edge) state_n = RUN;
      end
      ADJUST: begin
        if (pause_edge) resume_n = ~resume;
        // adjust steps wrap inside the selected field, never carry
        if (adj_tick) begin
          if (bus.sel) begin
            if (!bus.dir) min_n = (min_q == MIN_LAST) ? '0 : min_q + MIN_W'(1);
            else          min_n = (min_q == '0) ? MIN_LAST : min_q - MIN_W'(1);
          end else begin
            if (!bus.dir) sec_n = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            else          sec_n = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
          end
        end
        state_n = resume_n ? RUN : PAUSED;
      end
      default: state_n = EXPIRED;
    endcase
    if (bus.adj) begin
      if (state != ADJUST) resume_n = (state == RUN);
      state_n = ADJUST;
    end
    phase_n = (state_n == ADJUST) && (phase ^ blink_tick);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      resume      <= 1'b0;
      sec_cnt     <= '0;
      adj_cnt     <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      armed       <= 1'b0;
      pause_q     <= 1'b0;
      lap_q       <= 1'b0;
      min_q       <= '0;
      sec_q       <= 6'd0;
      lap_min_q   <= '0;
      lap_sec_q   <= 6'd0;
      lap_valid_q <= 1'b0;
      rollover_q  <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      state       <= state_n;
      resume      <= resume_n;
      min_q       <= min_n;
      sec_q       <= sec_n;
      rollover_q  <= rollover_n;
      armed       <= 1'b1;
      pause_q     <= bus.pause_btn;
      lap_q       <= bus.lap_btn;
      // prescalers sit at zero outside their state, so each entry starts a full period
      sec_cnt     <= (state != RUN || sec_tick) ? '0 : sec_cnt + SW'(1);
      adj_cnt     <= (state != ADJUST || adj_tick) ? '0 : adj_cnt + AW'(1);
      blink_cnt   <= (state != ADJUST || blink_tick) ? '0 : blink_cnt + BW'(1);
      phase       <= phase_n;
      blank_min_q <= phase_n & bus.sel;
      blank_sec_q <= phase_n & ~bus.sel;
      if (lap_edge) begin
        lap_min_q   <= min_q;
        lap_sec_q   <= sec_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign bus.minutes     = min_q;
  assign bus.seconds     = sec_q;
  assign bus.lap_minutes = lap_min_q;
  assign bus.lap_seconds = lap_sec_q;
  assign bus.lap_valid   = lap_valid_q;
  assign bus.running     = (state == RUN);
  assign bus.expired     = (state == EXPIRED);
  assign bus.rollover    = rollover_q;
  assign bus.blank_min   = blank_min_q;
  assign bus.blank_sec   = blank_sec_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, directed corner
// sequences and randomized stimulus against a behavioural time model.
module tb_stopwatch_core;
  localparam int TPS = 10;
  localparam int ADJT = 5;
  localparam int BT = 3;
  localparam int MM = 2;
  localparam int MW = 6;
  localparam int OW = 2 * MW + 12 + 6;
  localparam int M_RUN = 0, M_PAU = 1, M_ADJ = 2, M_EXP = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  stopwatch_if #(.MIN_W(MW)) bus ();

  stopwatch_core #(
    .TICKS_PER_SEC(TPS), .ADJ_TICKS(ADJT), .BLINK_TICKS(BT),
    .MIN_MAX(MM), .MIN_W(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: time as minutes/seconds, elapsed cycles per mode
  int m_mode, m_min, m_sec, m_run_el, m_adj_el, m_phase, m_resume;
  int m_lmin, m_lsec, m_lv, m_roll, m_bmin, m_bsec, m_prev_p, m_prev_l, m_armed;
  logic [OW-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = M_RUN; m_min = 0; m_sec = 0; m_run_el = 0; m_adj_el = 0;
    m_phase = 0; m_resume = 0; m_lmin = 0; m_lsec = 0; m_lv = 0; m_roll = 0;
    m_bmin = 0; m_bsec = 0; m_prev_p = 0; m_prev_l = 0; m_armed = 0;
  endtask

  task automatic model_step();
    int pe, le, tot, nxt, new_el, expire_now;
    pe = (bus.pause_btn && !m_prev_p && m_armed) ? 1 : 0;
    le = (bus.lap_btn && !m_prev_l && m_armed) ? 1 : 0;
    expire_now = 0;
    m_roll = 0;
    if (le != 0) begin
      m_lmin = m_min; m_lsec = m_sec; m_lv = 1;
    end
    if (m_mode == M_RUN && ((m_run_el + 1) % TPS) == 0) begin
      tot = m_min * 60 + m_sec;
      if (!bus.dir) begin
        m_roll = (tot == (MM + 1) * 60 - 1) ? 1 : 0;
        tot = (tot + 1) % ((MM + 1) * 60);
      end else if (tot == 0) begin
        expire_now = 1;
      end else begin
        tot = tot - 1;
      end
      m_min = tot / 60;
      m_sec = tot % 60;
    end
    if (m_mode == M_ADJ && ((m_adj_el + 1) % ADJT) == 0) begin
      if (bus.sel) m_min = (m_min + (bus.dir ? MM : 1)) % (MM + 1);
      else         m_sec = (m_sec + (bus.dir ? 59 : 1)) % 60;
    end
    if (m_mode == M_ADJ && pe != 0) m_resume = 1 - m_resume;
    case (m_mode)
      M_RUN:   nxt = (expire_now != 0) ? M_EXP : ((pe != 0) ? M_PAU : M_RUN);
      M_PAU:   nxt = (pe != 0) ? M_RUN : M_PAU;
      M_ADJ:   nxt = (m_resume != 0) ? M_RUN : M_PAU;
      default: nxt = M_EXP;
    endcase
    if (bus.adj) begin
      if (m_mode != M_ADJ) m_resume = (m_mode == M_RUN) ? 1 : 0;
      nxt = M_ADJ;
    end
    m_run_el = (m_mode == M_RUN) ? m_run_el + 1 : 0;
    new_el = (m_mode == M_ADJ) ? m_adj_el + 1 : 0;
    m_phase = (nxt == M_ADJ) ? (new_el / BT) % 2 : 0;
    m_adj_el = new_el;
    m_bmin = (m_phase != 0 && bus.sel) ? 1 : 0;
    m_bsec = (m_phase != 0 && !bus.sel) ? 1 : 0;
    m_mode = nxt;
    m_prev_p = bus.pause_btn ? 1 : 0;
    m_prev_l = bus.lap_btn ? 1 : 0;
    m_armed = 1;
  endtask

  function automatic logic [OW-1:0] model_vec();
    return {MW'(m_min), 6'(m_sec), MW'(m_lmin), 6'(m_lsec), (m_lv != 0),
            (m_mode == M_RUN), (m_mode == M_EXP), (m_roll != 0), (m_bmin != 0), (m_bsec != 0)};
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return {bus.minutes, bus.seconds, bus.lap_minutes, bus.lap_seconds, bus.lap_valid,
            bus.running, bus.expired, bus.rollover, bus.blank_min, bus.blank_sec};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  task automatic compare_model();
    logic [OW-1:0] e;
    logic [OW-1:0] a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL model_queue_empty cyc=%0d", cyc);
    end else begin
      e = exp_q.pop_front();
      a = dut_vec();
      if (a !== e) begin
        errors++;
        $display("FAIL model cyc=%0d got=%h expected=%h (min,sec,lmin,lsec,lv,run,exp,roll,bmin,bsec)",
                 cyc, a, e);
      end
    end
  endtask

  // driver tasks
  task automatic tick_cycle();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (2) tick_cycle();
    rst = 1'b0;
  endtask

  task automatic set_inputs(input logic p, input logic l, input logic a, input logic s, input logic d);
    bus.pause_btn = p; bus.lap_btn = l; bus.adj = a; bus.sel = s; bus.dir = d;
  endtask

  typedef struct {
    logic p, l, a, s, d;
    int   n;
    int   e_min, e_sec;
    logic e_run, e_exp, e_lv;
  } vec_t;

  vec_t tbl[16];
  int   n_roll;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 0,  2, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0,  1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0,  0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0,  0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1,  0,  0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5,  0,  0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0,  0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  0,  0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,  0,  1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5,  0,  0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5,  0, 59, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5,  2, 59, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,  2, 59, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  2, 59, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0,  0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  0,  0, 1'b1, 1'b0, 1'b1};

    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("reset_min", 32'(bus.minutes), 0);
    check("reset_sec", 32'(bus.seconds), 0);
    check("reset_running", 32'(bus.running), 1);
    check("reset_lap_valid", 32'(bus.lap_valid), 0);

    // vector table
    for (int r = 0; r < 16; r++) begin
      set_inputs(tbl[r].p, tbl[r].l, tbl[r].a, tbl[r].s, tbl[r].d);
      repeat (tbl[r].n) tick_cycle();
      check($sformatf("vec%0d_min", r), 32'(bus.minutes), tbl[r].e_min);
      check($sformatf("vec%0d_sec", r), 32'(bus.seconds), tbl[r].e_sec);
      check($sformatf("vec%0d_running", r), 32'(bus.running), 32'(tbl[r].e_run));
      check($sformatf("vec%0d_expired", r), 32'(bus.expired), 32'(tbl[r].e_exp));
      check($sformatf("vec%0d_lap_valid", r), 32'(bus.lap_valid), 32'(tbl[r].e_lv));
    end

    // full count-up cycle with a single rollover
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    n_roll = 0;
    for (int i = 0; i < 1800; i++) begin
      tick_cycle();
      if (bus.rollover) n_roll++;
      if (i == 8)    check("first_tick_early", 32'(bus.seconds), 0);
      if (i == 9)    check("first_tick", 32'(bus.seconds), 1);
      if (i == 1798) check("max_value", 32'(bus.minutes) * 60 + 32'(bus.seconds), 179);
    end
    check("wrap_value", 32'(bus.minutes) * 60 + 32'(bus.seconds), 0);
    check("wrap_rollover", 32'(bus.rollover), 1);
    check("rollover_count", 32'(n_roll), 1);
    tick_cycle();
    check("rollover_pulse_end", 32'(bus.rollover), 0);

    // pause held high across reset release must not toggle
    bus.pause_btn = 1'b1;
    do_reset();
    repeat (3) tick_cycle();
    check("held_pause_running", 32'(bus.running), 1);
    bus.pause_btn = 1'b0;

    // pause freeze and full-second resume
    do_reset();
    repeat (654) tick_cycle();
    check("pre_pause_value", 32'(bus.minutes) * 60 + 32'(bus.seconds), 65);
    bus.pause_btn = 1'b1; tick_cycle(); bus.pause_btn = 1'b0;
    repeat (50) tick_cycle();
    check("paused_value", 32'(bus.minutes) * 60 + 32'(bus.seconds), 65);
    check("paused_running", 32'(bus.running), 0);
    bus.pause_btn = 1'b1; tick_cycle(); bus.pause_btn = 1'b0;
    check("resumed_running", 32'(bus.running), 1);
    repeat (9) tick_cycle();
    check("resume_no_early_tick", 32'(bus.seconds), 5);
    tick_cycle();
    check("resume_tick", 32'(bus.seconds), 6);

    // adjust seconds then minutes, wrapping inside each field
    do_reset();
    repeat (580) tick_cycle();
    check("pre_adj_sec", 32'(bus.seconds), 58);
    bus.adj = 1'b1;
    for (int j = 0; j <= 15; j++) begin
      tick_cycle();
      if (j == 5)  check("adj_sec_59", 32'(bus.seconds), 59);
      if (j == 10) check("adj_sec_00", 32'(bus.seconds), 0);
      if (j == 15) check("adj_sec_01", 32'(bus.seconds), 1);
    end
    check("adj_min_unchanged", 32'(bus.minutes), 0);
    bus.sel = 1'b1; bus.dir = 1'b1;
    repeat (5) tick_cycle();
    check("adj_min_down_wrap", 32'(bus.minutes), MM);
    bus.dir = 1'b0;
    repeat (5) tick_cycle();
    check("adj_min_up_wrap", 32'(bus.minutes), 0);
    check("adj_sec_kept", 32'(bus.seconds), 1);

    // blink on minute digits
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    bus.adj = 1'b1; bus.sel = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick_cycle();
      check($sformatf("blink_min_%0d", j), 32'(bus.blank_min), (j / 3) % 2);
      check($sformatf("blink_sec_%0d", j), 32'(bus.blank_sec), 0);
    end

    // lap coincident with a tick, then async reset mid-adjust
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (79) tick_cycle();
    check("pre_lap_sec", 32'(bus.seconds), 7);
    bus.lap_btn = 1'b1; tick_cycle(); bus.lap_btn = 1'b0;
    check("lap_tick_sec", 32'(bus.seconds), 8);
    check("lap_sec", 32'(bus.lap_seconds), 7);
    check("lap_min", 32'(bus.lap_minutes), 0);
    check("lap_valid", 32'(bus.lap_valid), 1);
    bus.adj = 1'b1;
    repeat (7) tick_cycle();
    check("adj_state", 32'(bus.state_dbg), 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sec", 32'(bus.seconds), 0);
    check("async_rst_lap_valid", 32'(bus.lap_valid), 0);
    check("async_rst_lap_sec", 32'(bus.lap_seconds), 0);
    check("async_rst_running", 32'(bus.running), 1);
    check("async_rst_blank", 32'({bus.blank_min, bus.blank_sec}), 0);
    check("async_rst_state", 32'(bus.state_dbg), 0);
    model_reset();
    exp_q.delete();
    bus.adj = 1'b0;
    repeat (2) tick_cycle();
    rst = 1'b0;

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) bus.pause_btn = ~bus.pause_btn;
      if ($urandom_range(0, 99) < 4) bus.lap_btn = ~bus.lap_btn;
      if ($urandom_range(0, 99) < 2) bus.adj = ~bus.adj;
      if ($urandom_range(0, 99) < 8) bus.sel = ~bus.sel;
      if ($urandom_range(0, 99) < 3) bus.dir = ~bus.dir;
      if ($urandom_range(0, 999) < 2) do_reset();
      else tick_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
